fifo_frame_reader: RTL



---
 rtl/fifo_frame_reader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_frame_reader.sv
// Read-side frame parser for a first-word-fall-through FIFO: hunts for a sync header,
// streams payload words through a registered valid/ready port and verifies the checksum.
module fifo_frame_reader #(
  parameter int          DATA_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter bit          CHECK_EN   = 1'b1
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  fifo_rd_vld,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eof,
  output logic                  frame_done,
  output logic                  frame_err,
  output logic                  hdr_err,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
);

  typedef enum logic [1:0] {HUNT, PAYLOAD, CHECK} state_t;

  state_t                state, next_state;
  logic [7:0]            remaining;
  logic [DATA_WIDTH-1:0] acc;
  logic                  sof_flag;
  logic                  pop, hdr_ok, last_word, load;

  assign pop       = fifo_rd_en && fifo_rd_vld;
  assign hdr_ok    = (fifo_rd_data[15:8] == SYNC_BYTE) && (fifo_rd_data[7:0] != 8'd0);
  assign last_word = (remaining == 8'd1);
  assign load      = (state == PAYLOAD) && pop;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) state <= HUNT;
    else        state <= next_state;
  end

  // NOTE: each combinational output gets a default first so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      HUNT:    if (pop && hdr_ok) next_state = PAYLOAD;
      PAYLOAD: if (pop && last_word) next_state = CHECK_EN ? CHECK : HUNT;
      CHECK:   if (pop) next_state = HUNT;
      default: next_state = HUNT;
    endcase
  end

  // Only payload pops wait on the output register; header and checksum words drain freely.
  always_comb begin
    fifo_rd_en = 1'b0;
    case (state)
      HUNT:    fifo_rd_en = fifo_rd_vld;
      PAYLOAD: fifo_rd_en = fifo_rd_vld && (!m_valid || m_ready);
      CHECK:   fifo_rd_en = fifo_rd_vld;
      default: fifo_rd_en = 1'b0;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      remaining  <= '0;
      acc        <= '0;
      sof_flag   <= 1'b0;
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      m_eof      <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      hdr_err    <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      hdr_err    <= 1'b0;

      if (load) begin
        m_data  <= fifo_rd_data;
        m_valid <= 1'b1;
        m_sof   <= sof_flag;
        m_eof   <= last_word;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (pop) begin
            if (hdr_ok) begin
              remaining <= fifo_rd_data[7:0];
              acc       <= '0;
              sof_flag  <= 1'b1;
            end else begin
              hdr_err <= 1'b1;
              err_cnt <= err_cnt + 16'd1;
            end
          end
        end
        PAYLOAD: begin
          if (pop) begin
            acc       <= acc + fifo_rd_data;
            remaining <= remaining - 8'd1;
            sof_flag  <= 1'b0;
            // Without a checksum word the frame is complete on its last payload pop.
            if (last_word && !CHECK_EN) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 16'd1;
            end
          end
        end
        CHECK: begin
          if (pop) begin
            frame_done <= 1'b1;
            frame_err  <= (fifo_rd_data != acc);
            if (fifo_rd_data != acc) err_cnt   <= err_cnt + 16'd1;
            else                     frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
